// File: rtl/riscv_pkg.sv
// riscv_pkg: shared register-address width and hazard FSM state encoding
package riscv_pkg;
   localparam int REG_ADDR_W = 5;
   typedef enum logic [1:0] {
      NORMAL   = 2'b00,
      LU_STALL = 2'b01,
      BR_FLUSH = 2'b10
   } hz_state_t;
endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: free-running stall/flush event counters, wrapping modulo 2^32
//   clk, rst_n           : clock, asynchronous active-low reset
//   i_stall, i_flush     : per-cycle event strobes
//   o_stall_cnt/o_flush_cnt : event totals since reset
module hazard_perf_cnt (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_stall,
   input  logic        i_flush,
   output logic [31:0] o_stall_cnt,
   output logic [31:0] o_flush_cnt
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         o_stall_cnt <= '0;
         o_flush_cnt <= '0;
      end else begin
         o_stall_cnt <= o_stall_cnt + 32'(i_stall);
         o_flush_cnt <= o_flush_cnt + 32'(i_flush);
      end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall / taken-branch flush control with MEM/WB destination tracking
//   clk, rst_n                       : clock, asynchronous active-low reset
//   rs1_id, rs2_id                   : ID-stage source registers
//   rd_ex, reg_write_ex, mem_read_ex : EX-stage destination, write enable, load flag
//   branch_taken_ex                  : EX-stage redirect
//   rd_mem/rd_wb, reg_write_mem/wb   : delayed destinations for the forwarding unit
//   stall_pc, stall_if_id            : hold PC and IF/ID
//   flush_if_id, flush_id_ex         : squash IF/ID, bubble ID/EX
//   hz_state                         : FSM state
//   stall_cnt, flush_cnt             : event counters, present only with HAZ_PERF_EN defined
module hazard_unit
   import riscv_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] rs1_id,
   input  logic [REG_ADDR_W-1:0] rs2_id,
   input  logic [REG_ADDR_W-1:0] rd_ex,
   input  logic                  reg_write_ex,
   input  logic                  mem_read_ex,
   input  logic                  branch_taken_ex,
   output logic [REG_ADDR_W-1:0] rd_mem,
   output logic [REG_ADDR_W-1:0] rd_wb,
   output logic                  reg_write_mem,
   output logic                  reg_write_wb,
   output logic                  stall_pc,
   output logic                  stall_if_id,
   output logic                  flush_if_id,
   output logic                  flush_id_ex,
   output logic [1:0]            hz_state
`ifdef HAZ_PERF_EN
   ,
   output logic [31:0]           stall_cnt,
   output logic [31:0]           flush_cnt
`endif
);
   hz_state_t r_state;
   logic      w_lu;
   logic      w_normal;
   assign w_lu = mem_read_ex & reg_write_ex & (rd_ex != '0) &
                 ((rd_ex == rs1_id) | (rd_ex == rs2_id));
   // rst_n gates the combinational outputs so they read 0 throughout reset
   assign w_normal    = rst_n & (r_state == NORMAL);
   assign stall_pc    = w_normal & w_lu & ~branch_taken_ex;
   assign stall_if_id = stall_pc;
   assign flush_if_id = w_normal & branch_taken_ex;
   assign flush_id_ex = w_normal & (branch_taken_ex | w_lu);
   assign hz_state    = r_state;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd_mem        <= '0;
         rd_wb         <= '0;
         reg_write_mem <= 1'b0;
         reg_write_wb  <= 1'b0;
         r_state       <= NORMAL;
      end else begin
         rd_mem        <= rd_ex;
         reg_write_mem <= reg_write_ex;
         rd_wb         <= rd_mem;
         reg_write_wb  <= reg_write_mem;
         // EX holds a bubble in either non-NORMAL state, so its inputs are ignored there
         r_state       <= (r_state != NORMAL) ? NORMAL :
                          branch_taken_ex     ? BR_FLUSH :
                          w_lu                ? LU_STALL : NORMAL;
      end
`ifdef HAZ_PERF_EN
   hazard_perf_cnt u_perf (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_stall     (stall_pc),
      .i_flush     (flush_if_id),
      .o_stall_cnt (stall_cnt),
      .o_flush_cnt (flush_cnt)
   );
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scenarios checked against a behavioural model every cycle
module tb_hazard_unit;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] rs1_id = '0, rs2_id = '0, rd_ex = '0;
   logic       reg_write_ex = 1'b0, mem_read_ex = 1'b0, branch_taken_ex = 1'b0;
   logic [4:0] rd_mem, rd_wb;
   logic       reg_write_mem, reg_write_wb, stall_pc, stall_if_id, flush_if_id, flush_id_ex;
   logic [1:0] hz_state;
`ifdef HAZ_PERF_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif
   int n_cmp = 0, n_bad = 0;

   hazard_unit dut (
      .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
      .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex),
      .rd_mem(rd_mem), .rd_wb(rd_wb), .reg_write_mem(reg_write_mem), .reg_write_wb(reg_write_wb),
      .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
      .flush_id_ex(flush_id_ex), .hz_state(hz_state)
`ifdef HAZ_PERF_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   // model: history of EX destinations, a "busy" flag for the one-cycle bubble, event totals
   int          m_rd_mem, m_rd_wb, m_busy_kind;
   bit          m_wm, m_ww;
   int unsigned m_sc, m_fc;

   function automatic bit m_lu();
      return mem_read_ex && reg_write_ex && rd_ex != 0 && (rd_ex == rs1_id || rd_ex == rs2_id);
   endfunction
   function automatic bit m_free();
      return rst_n && m_busy_kind == 0;
   endfunction
   function automatic bit e_stall();
      return m_free() && m_lu() && !branch_taken_ex;
   endfunction
   function automatic bit e_fif();
      return m_free() && branch_taken_ex;
   endfunction
   function automatic bit e_fidex();
      return m_free() && (branch_taken_ex || m_lu());
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_rd_mem = 0; m_rd_wb = 0; m_wm = 0; m_ww = 0; m_busy_kind = 0; m_sc = 0; m_fc = 0;
      end else begin
         m_sc += 32'(e_stall());
         m_fc += 32'(e_fif());
         if (m_busy_kind != 0) m_busy_kind = 0;
         else if (branch_taken_ex) m_busy_kind = 2;
         else if (m_lu()) m_busy_kind = 1;
         m_rd_wb = m_rd_mem; m_ww = m_wm;
         m_rd_mem = int'(rd_ex); m_wm = reg_write_ex;
      end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("m_rd_mem", 32'(rd_mem), 32'(m_rd_mem));
      chk("m_rd_wb", 32'(rd_wb), 32'(m_rd_wb));
      chk("m_rw_mem", 32'(reg_write_mem), 32'(m_wm));
      chk("m_rw_wb", 32'(reg_write_wb), 32'(m_ww));
      chk("m_state", 32'(hz_state), 32'(m_busy_kind));
      chk("m_stall_pc", 32'(stall_pc), 32'(e_stall()));
      chk("m_stall_if_id", 32'(stall_if_id), 32'(e_stall()));
      chk("m_flush_if_id", 32'(flush_if_id), 32'(e_fif()));
      chk("m_flush_id_ex", 32'(flush_id_ex), 32'(e_fidex()));
`ifdef HAZ_PERF_EN
      chk("m_stall_cnt", stall_cnt, m_sc);
      chk("m_flush_cnt", flush_cnt, m_fc);
`endif
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic set_in(input int r1, input int r2, input int rd, input bit rw, input bit mr, input bit br);
      rs1_id = 5'(r1); rs2_id = 5'(r2); rd_ex = 5'(rd);
      reg_write_ex = rw; mem_read_ex = mr; branch_taken_ex = br;
      #1;
   endtask
   task automatic ctl(input string tag, input bit s, input bit fi, input bit fe);
      chk({tag, "_stall_pc"}, 32'(stall_pc), 32'(s));
      chk({tag, "_stall_if_id"}, 32'(stall_if_id), 32'(s));
      chk({tag, "_flush_if_id"}, 32'(flush_if_id), 32'(fi));
      chk({tag, "_flush_id_ex"}, 32'(flush_id_ex), 32'(fe));
   endtask

   initial begin
      tick(); tick();
      chk("rst_rd_mem", 32'(rd_mem), 0);
      chk("rst_state", 32'(hz_state), 0);
      set_in(4, 4, 4, 1, 1, 1);
      ctl("rst_ctl", 0, 0, 0);
      set_in(0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      tick();
      // pipeline
      set_in(1, 2, 5, 1, 0, 0);
      ctl("pipe0", 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0);
      chk("pipe_rd_mem", 32'(rd_mem), 5);
      chk("pipe_rw_mem", 32'(reg_write_mem), 1);
      tick();
      chk("pipe_rd_wb", 32'(rd_wb), 5);
      chk("pipe_rw_wb", 32'(reg_write_wb), 1);
      chk("pipe_rd_mem2", 32'(rd_mem), 0);
      // load-use on rs2, held through LU_STALL to show masking
      set_in(1, 7, 7, 1, 1, 0);
      ctl("lu1", 1, 0, 1);
      tick();
      chk("lu1_state", 32'(hz_state), 1);
      ctl("lu1_mask", 0, 0, 0);
`ifdef HAZ_PERF_EN
      chk("lu1_flush_cnt", flush_cnt, 0);
      chk("lu1_stall_cnt", stall_cnt, 1);
`endif
      set_in(0, 0, 0, 0, 0, 0);
      tick();
      chk("lu1_back", 32'(hz_state), 0);
      // x0 load
      set_in(0, 0, 0, 1, 1, 0);
      ctl("x0", 0, 0, 0);
      tick();
      chk("x0_state", 32'(hz_state), 0);
      // branch vs load-use collision on x3
      set_in(3, 6, 3, 1, 1, 1);
      ctl("coll", 0, 1, 1);
      tick();
      chk("coll_state", 32'(hz_state), 2);
      ctl("coll_mask", 0, 0, 0);
      set_in(0, 0, 0, 0, 0, 0);
      tick();
      chk("coll_back", 32'(hz_state), 0);
      // second load-use on rs1
      set_in(12, 1, 12, 1, 1, 0);
      ctl("lu2", 1, 0, 1);
      tick();
      set_in(0, 0, 0, 0, 0, 0);
      tick();
      // non-load and mismatched writes never stall
      set_in(8, 9, 8, 1, 0, 0);
      ctl("noload", 0, 0, 0);
      set_in(8, 9, 10, 1, 1, 0);
      ctl("nomatch", 0, 0, 0);
      // plain branch
      set_in(0, 0, 0, 0, 0, 1);
      ctl("br2", 0, 1, 1);
      tick();
      set_in(0, 0, 0, 0, 0, 0);
      tick();
      // third load-use
      set_in(2, 31, 31, 1, 1, 0);
      ctl("lu3", 1, 0, 1);
      tick();
      set_in(0, 0, 0, 0, 0, 0);
      tick();
`ifdef HAZ_PERF_EN
      chk("perf_stall_cnt", stall_cnt, 3);
      chk("perf_flush_cnt", flush_cnt, 2);
`endif
      // reset pulsed mid-stall
      set_in(9, 0, 9, 1, 1, 0);
      tick();
      chk("rm_state", 32'(hz_state), 1);
      chk("rm_rd_mem", 32'(rd_mem), 9);
      rst_n = 1'b0;
      #1;
      chk("rm_rst_state", 32'(hz_state), 0);
      chk("rm_rst_rd_mem", 32'(rd_mem), 0);
      chk("rm_rst_rw_mem", 32'(reg_write_mem), 0);
      ctl("rm_rst", 0, 0, 0);
      set_in(0, 0, 0, 0, 0, 0);
      tick();
      rst_n = 1'b1;
      chk("rm_post_state", 32'(hz_state), 0);
      tick();
      chk("rm_post_state2", 32'(hz_state), 0);
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The module SHALL have these ports, in this order:
- clk, input, 1, sole clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- rs1_id, input, 5, ID-stage source register 1.
- rs2_id, input, 5, ID-stage source register 2.
- rd_ex, input, 5, EX-stage destination register.
- reg_write_ex, input, 1, EX-stage instruction writes rd.
- mem_read_ex, input, 1, EX-stage instruction is a load.
- branch_taken_ex, input, 1, EX-stage branch or jump redirects the PC.
- rd_mem, output, 5, MEM-stage destination register for forward_unit.
- rd_wb, output, 5, WB-stage destination register for forward_unit.
- reg_write_mem, output, 1, MEM-stage write enable.
- reg_write_wb, output, 1, WB-stage write enable.
- stall_pc, output, 1, hold the PC.
- stall_if_id, output, 1, hold the IF/ID register.
- flush_if_id, output, 1, clear IF/ID to a NOP.
- flush_id_ex, output, 1, insert a bubble into ID/EX.
- hz_state, output, 2, current FSM state.

REQ-002 The module SHALL use a single clock domain; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-003 On each rising clk edge, the module SHALL register rd_mem<=rd_ex, reg_write_mem<=reg_write_ex, rd_wb<=rd_mem and reg_write_wb<=reg_write_mem, giving exactly one cycle per stage.

REQ-004 The EX instruction SHALL always advance to MEM; stalls and flushes SHALL NOT gate the REQ-003 pipeline.

REQ-005 The load-use condition lu SHALL be defined as mem_read_ex & reg_write_ex & (rd_ex!=0) & ((rd_ex==rs1_id)|(rd_ex==rs2_id)).

REQ-006 The FSM SHALL have three states, encoded on hz_state: NORMAL=2'b00, LU_STALL=2'b01, BR_FLUSH=2'b10.

REQ-007 In NORMAL, branch_taken_ex=1 SHALL transition to BR_FLUSH.

REQ-008 In NORMAL, lu=1 with branch_taken_ex=0 SHALL transition to LU_STALL.

REQ-009 In NORMAL, any other input combination SHALL keep the FSM in NORMAL.

REQ-010 LU_STALL and BR_FLUSH SHALL each return to NORMAL after exactly one cycle, unconditionally.

REQ-011 While in LU_STALL or BR_FLUSH, lu and branch_taken_ex SHALL be ignored, because EX holds a bubble.

REQ-012 The control outputs SHALL be combinational from the current state and inputs:
- stall_pc = stall_if_id = NORMAL & lu & ~branch_taken_ex.
- flush_if_id = NORMAL & branch_taken_ex.
- flush_id_ex = NORMAL & (branch_taken_ex | lu).

REQ-013 When a taken branch and a load-use hazard occur in the same cycle, the branch SHALL win: no stall, and both flushes asserted.

REQ-014 Register x0 SHALL never cause a stall, whether as rd_ex or as a source register.

Reset
REQ-015 While rst_n=0, the outputs SHALL be: rd_mem=0, rd_wb=0, reg_write_mem=0, reg_write_wb=0, FSM=NORMAL, all stall and flush outputs 0.

REQ-016 Reset asserted mid-stall or mid-flush SHALL abort the operation immediately; the first post-reset cycle SHALL be NORMAL.

Configuration
REQ-017 When HAZ_PERF_EN is defined, the module SHALL add output ports stall_cnt[31:0] and flush_cnt[31:0]:
- stall_cnt increments on each cycle with stall_pc=1.
- flush_cnt increments on each cycle with flush_if_id=1.
- Both wrap modulo 2^32 and reset to 0.

REQ-018 When HAZ_PERF_EN is undefined, those ports and counters SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-019 The shared package riscv_pkg SHALL hold REG_ADDR_W=5 and the hz_state_t enum {NORMAL, LU_STALL, BR_FLUSH}.

REQ-020 The counters SHALL be a sub-module hazard_perf_cnt, instantiated only under HAZ_PERF_EN.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Pipeline: rd_ex=5, reg_write_ex=1 at cycle 0 -> rd_mem=5 at cycle 1; rd_wb=5, reg_write_wb=1 at cycle 2.
- Load-use: mem_read_ex=1, rd_ex=7, rs2_id=7 -> stall_pc=stall_if_id=flush_id_ex=1 for exactly one cycle; hz_state=01 the next cycle; flush_cnt unchanged.
- x0 load: mem_read_ex=1, rd_ex=0, rs1_id=0 -> all stall and flush outputs stay 0.
- Collision: branch_taken_ex=1 together with a load-use on rd_ex=3 -> stall_pc=0, flush_if_id=flush_id_ex=1, next hz_state=10.
- Masking: rst_n pulsed low while hz_state=01 -> all outputs 0 immediately; an input held at lu=1 in LU_STALL causes no second stall.
- HAZ_PERF_EN: three separate load-use events and two branches -> stall_cnt=3, flush_cnt=2.
